pedestrian_request: RTL

//  Pedestrian push-button front end for the traffic-light controller (sits directly upstream of it).

---
 rtl/pedestrian_request.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pedestrian_request.sv
// Pedestrian push-button front end: sync, debounce, request latch, lockout.
// Define WAIT_BLINK_EN to make the WAIT lamp blink while a request is pending.
module pedestrian_request #(
    parameter int unsigned DEBOUNCE_CYCLES   = 160000,
    parameter int unsigned LOCKOUT_CYCLES    = 80000000,
    parameter int unsigned BLINK_HALF_PERIOD = 4000000
) (
    input  logic pin3_clk_16mhz,
    input  logic pin1_rst,
    input  logic pin9_button_n,
    input  logic ped_ack,
    output logic ped_request,
    output logic pin10_wait_lamp
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PENDING = 2'b01,
        LOCKOUT = 2'b10
    } state_t;

    localparam logic [29:0] DB_LAST   = 30'(DEBOUNCE_CYCLES - 1);
    localparam logic [29:0] LOCK_LOAD = 30'(LOCKOUT_CYCLES - 1);

    if ((DEBOUNCE_CYCLES < 1) || (LOCKOUT_CYCLES < 1) ||
        (LOCKOUT_CYCLES >= 32'h4000_0000) ||
        (BLINK_HALF_PERIOD < 1)) begin : g_bad_params
        $error("pedestrian_request: parameter out of range");
    end

    logic        sync1;
    logic        sync2;
    logic        btn_s;
    logic        db_state;
    logic        db_prev;
    logic [29:0] db_cnt;
    logic        press_evt;

    state_t      state_q;
    state_t      state_d;
    logic [29:0] lock_cnt_q;
    logic [29:0] lock_cnt_d;

    always_ff @(posedge pin3_clk_16mhz or posedge pin1_rst) begin
        if (pin1_rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= pin9_button_n;
            sync2 <= sync1;
        end
    end

    assign btn_s = ~sync2;

    // A new level is accepted only after DEBOUNCE_CYCLES identical samples.
    always_ff @(posedge pin3_clk_16mhz or posedge pin1_rst) begin
        if (pin1_rst) begin
            db_state <= 1'b0;
            db_cnt   <= '0;
        end else if (btn_s == db_state) begin
            db_cnt   <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_state <= btn_s;
            db_cnt   <= '0;
        end else begin
            db_cnt   <= db_cnt + 30'd1;
        end
    end

    always_ff @(posedge pin3_clk_16mhz or posedge pin1_rst) begin
        if (pin1_rst) begin
            db_prev <= 1'b0;
        end else begin
            db_prev <= db_state;
        end
    end

    assign press_evt = db_state & ~db_prev;

    always_ff @(posedge pin3_clk_16mhz or posedge pin1_rst) begin
        if (pin1_rst) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (press_evt) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (ped_ack) begin
                    state_d    = LOCKOUT;
                    lock_cnt_d = LOCK_LOAD;
                end
            end
            LOCKOUT: begin
                if (lock_cnt_q != 30'd0) begin
                    lock_cnt_d = lock_cnt_q - 30'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ped_request = (state_q == PENDING);

`ifdef WAIT_BLINK_EN
    localparam logic [29:0] BLINK_LAST = 30'(BLINK_HALF_PERIOD - 1);

    logic [29:0] blink_cnt_q;
    logic        lamp_q;

    // Lamp follows the next state so it is already lit on the first PENDING cycle.
    always_ff @(posedge pin3_clk_16mhz or posedge pin1_rst) begin
        if (pin1_rst) begin
            blink_cnt_q <= '0;
            lamp_q      <= 1'b0;
        end else if (state_d != PENDING) begin
            blink_cnt_q <= '0;
            lamp_q      <= 1'b0;
        end else if (state_q != PENDING) begin
            blink_cnt_q <= '0;
            lamp_q      <= 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            lamp_q      <= ~lamp_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 30'd1;
        end
    end

    assign pin10_wait_lamp = lamp_q;
`else
    assign pin10_wait_lamp = (state_q == PENDING);
`endif

endmodule
